// File: rtl/note_track_pkg.sv
// ============================================================================
// Module  : note_track_pkg
// Brief   : Shared sweep-mode encodings and direction constants for note lanes.
// Revision: 1.0 - initial multi-lane release
// ============================================================================
`default_nettype none

package note_track_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_BOUNCE  = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/note_track_lane.sv
// ============================================================================
// Module  : note_track_lane
// Brief   : One note lane: coordinate sweeper between START and STOP.
// Revision: 1.0 - initial multi-lane release
// ============================================================================
`default_nettype none

module note_track_lane
  import note_track_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int START = 180,
  parameter int STOP  = 196,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tick_i,
  input  mode_t            mode_i,
  input  logic             en_i,
  input  logic             restart_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             wrap_o,
  output logic             done_o
);

  localparam logic [WIDTH-1:0] c_start_w = WIDTH'(START);
  localparam logic [WIDTH-1:0] c_stop_w  = WIDTH'(STOP);
  localparam logic [WIDTH-1:0] c_step_w  = WIDTH'(STEP);
  localparam logic [WIDTH:0]   c_stop_x  = (WIDTH+1)'(STOP);
  localparam logic [WIDTH:0]   c_floor_x = (WIDTH+1)'(START + STEP);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;

  logic             w_event;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_up;
  logic [WIDTH-1:0] w_dn;

  assign w_event = tick_i & en_i;
  assign w_sum   = {1'b0, data_q} + {1'b0, c_step_w};
  assign w_up    = (w_sum > c_stop_x) ? c_stop_w : w_sum[WIDTH-1:0];
  // Below START+STEP a full step would undershoot START, so clamp there.
  assign w_dn    = ({1'b0, data_q} < c_floor_x) ? c_start_w : (data_q - c_step_w);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q  <= c_start_w;
      valid_q <= 1'b0;
      dir_q   <= DIR_UP;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    dir_d   = dir_q;
    done_d  = done_q;
    wrap_d  = 1'b0;
    if (restart_i) begin
      data_d  = c_start_w;
      dir_d   = DIR_UP;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else if (w_event && (mode_i != MODE_HOLD)) begin
      if (!valid_q) begin
        valid_d = 1'b1;
      end else begin
        case (mode_i)
          MODE_WRAP: begin
            dir_d = DIR_UP;
            if (data_q == c_stop_w) begin
              data_d = c_start_w;
              wrap_d = 1'b1;
            end else begin
              data_d = w_up;
            end
          end
          MODE_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              if (data_q == c_stop_w) begin
                dir_d  = DIR_DOWN;
                wrap_d = 1'b1;
                data_d = w_dn;
              end else begin
                data_d = w_up;
              end
            end else if (data_q == c_start_w) begin
              dir_d  = DIR_UP;
              wrap_d = 1'b1;
              data_d = w_up;
            end else begin
              data_d = w_dn;
            end
          end
          MODE_ONESHOT: begin
            // Clamped step also covers entering one-shot already parked at STOP.
            dir_d = DIR_UP;
            if (!done_q) begin
              data_d = w_up;
              if (w_up == c_stop_w) begin
                done_d = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign wrap_o  = wrap_q;
  assign done_o  = done_q;

endmodule

`default_nettype wire

// File: rtl/note_track_gen.sv
// ============================================================================
// Module  : note_track_gen
// Brief   : LANES independent note-position sweepers sharing tick and mode.
// Revision: 1.0 - initial multi-lane release
// ============================================================================
`default_nettype none

module note_track_gen
  import note_track_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int START = 180,
  parameter int STOP  = 196,
  parameter int STEP  = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   tick_i,
  input  logic [1:0]             mode_i,
  input  logic [LANES-1:0]       lane_en_i,
  input  logic [LANES-1:0]       lane_restart_i,
  output logic [LANES*WIDTH-1:0] lane_data_o,
  output logic [LANES-1:0]       lane_valid_o,
  output logic [LANES-1:0]       lane_wrap_o,
  output logic [LANES-1:0]       lane_done_o
);

  mode_t w_mode;
  assign w_mode = mode_t'(mode_i);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    note_track_lane #(
      .WIDTH(WIDTH),
      .START(START),
      .STOP (STOP),
      .STEP (STEP)
    ) u_lane (
      .clk      (clk),
      .resetn   (resetn),
      .tick_i   (tick_i),
      .mode_i   (w_mode),
      .en_i     (lane_en_i[i]),
      .restart_i(lane_restart_i[i]),
      .data_o   (lane_data_o[i*WIDTH +: WIDTH]),
      .valid_o  (lane_valid_o[i]),
      .wrap_o   (lane_wrap_o[i]),
      .done_o   (lane_done_o[i])
    );
  end

endmodule

`default_nettype wire
